// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Requester-side bundle of alu_arbiter: two issue channels (VALID/READY with
// operands and opcode), the shared result bus with one strobe per requester,
// and the FLUSH request / BUSY status pair.
//   master : instruction sequencer (drives requests and FLUSH)
//   slave  : alu_arbiter (drives grants, results and BUSY)
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
   parameter int DWIDTH  = 8,
   parameter int OPWIDTH = 4
);
   logic               REQ0_VALID;
   logic               REQ1_VALID;
   logic               REQ0_READY;
   logic               REQ1_READY;
   logic [DWIDTH-1:0]  REQ0_A;
   logic [DWIDTH-1:0]  REQ0_B;
   logic [DWIDTH-1:0]  REQ1_A;
   logic [DWIDTH-1:0]  REQ1_B;
   logic [OPWIDTH-1:0] REQ0_S;
   logic [OPWIDTH-1:0] REQ1_S;
   logic               RSP0_VALID;
   logic               RSP1_VALID;
   logic [DWIDTH-1:0]  RSP_Y;
   logic               RSP_C;
   logic               RSP_V;
   logic               RSP_Z;
   logic               FLUSH;
   logic               BUSY;

   modport master (
      output REQ0_VALID, REQ1_VALID, REQ0_A, REQ0_B, REQ1_A, REQ1_B,
             REQ0_S, REQ1_S, FLUSH,
      input  REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID,
             RSP_Y, RSP_C, RSP_V, RSP_Z, BUSY
   );

   modport slave (
      input  REQ0_VALID, REQ1_VALID, REQ0_A, REQ0_B, REQ1_A, REQ1_B,
             REQ0_S, REQ1_S, FLUSH,
      output REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID,
             RSP_Y, RSP_C, RSP_V, RSP_Z, BUSY
   );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one pipelined ALU between two requesters. Issue slots are granted
// round-robin, one operation per cycle. A tag (valid + requester id) follows
// each operation through the ALU latency so the result and flags are routed
// back to the requester that issued it. The block also owns ALU_CLR: it
// clears the ALU after reset and runs a drain-then-clear sequence on FLUSH.
//
// Ports
//   CLK, CLR_N       : clock (rising edge), asynchronous active-low reset
//   req (slave)      : requester handshakes, shared result bus, FLUSH/BUSY
//   ALU_A/B/S/CLR    : registered drive to the ALU
//   ALU_Y/C/V/Z      : ALU result and flags
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int DWIDTH  = 8,
   parameter int OPWIDTH = 4,
   parameter int ALU_LAT = 2,
   parameter int CLR_CYC = 2
) (
   input  logic               CLK,
   input  logic               CLR_N,
   alu_arbiter_if.slave       req,
   output logic [DWIDTH-1:0]  ALU_A,
   output logic [DWIDTH-1:0]  ALU_B,
   output logic [OPWIDTH-1:0] ALU_S,
   output logic               ALU_CLR,
   input  logic [DWIDTH-1:0]  ALU_Y,
   input  logic               ALU_C,
   input  logic               ALU_V,
   input  logic               ALU_Z
);

   localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

   typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN, ST_CLEAR} state_t;

   state_t              state_reg, state_next;
   logic [CW-1:0]       clr_cnt_reg, clr_cnt_next;
   logic                clr_reg, clr_next;

   // Id of the requester granted most recently; resets to 1 so REQ0 wins
   // the first contended cycle.
   logic                last_reg;

   logic [DWIDTH-1:0]   a_reg, b_reg;
   logic [OPWIDTH-1:0]  s_reg;

   // Issue-stage tag sits alongside ALU_A/B/S; the ALU_LAT-deep shift behind
   // it lines the tag up with the cycle in which ALU_Y holds that result.
   logic                iss_vld_reg, iss_id_reg;
   logic [ALU_LAT-1:0]  tag_vld_reg, tag_id_reg;
   logic [ALU_LAT-1:0]  tag_vld_next, tag_id_next;

   logic                rsp0_vld_reg, rsp1_vld_reg;
   logic [DWIDTH-1:0]   rsp_y_reg;
   logic                rsp_c_reg, rsp_v_reg, rsp_z_reg;

   logic                grant_en, rdy0, rdy1, xfer, win_id, in_flight;
   logic                out_vld, out_id;

   // ------------------------------------------------------------------
   // Grant logic (combinational)
   // ------------------------------------------------------------------
   assign grant_en = (state_reg == ST_RUN) && !req.FLUSH;
   assign rdy0     = grant_en && req.REQ0_VALID && (!req.REQ1_VALID || last_reg);
   assign rdy1     = grant_en && req.REQ1_VALID && (!req.REQ0_VALID || !last_reg);
   assign xfer     = rdy0 || rdy1;
   assign win_id   = rdy1;

   assign in_flight = iss_vld_reg || (|tag_vld_reg);
   assign out_vld   = tag_vld_reg[ALU_LAT-1];
   assign out_id    = tag_id_reg[ALU_LAT-1];

   // ------------------------------------------------------------------
   // Tag pipe next-state: stage 0 loads from the issue stage, every other
   // stage from its predecessor.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < ALU_LAT; gi++) begin : g_tag
         if (gi == 0) begin : g_head
            assign tag_vld_next[gi] = iss_vld_reg;
            assign tag_id_next[gi]  = iss_id_reg;
         end else begin : g_body
            assign tag_vld_next[gi] = tag_vld_reg[gi-1];
            assign tag_id_next[gi]  = tag_id_reg[gi-1];
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // FSM: next state and ALU_CLR / clear counter
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      clr_next     = clr_reg;
      case (state_reg)
         ST_INIT, ST_CLEAR: begin
            if (clr_cnt_reg == CW'(CLR_CYC - 1)) begin
               state_next   = ST_RUN;
               clr_next     = 1'b0;
               clr_cnt_next = '0;
            end else begin
               clr_cnt_next = clr_cnt_reg + 1'b1;
            end
         end
         ST_RUN: begin
            if (req.FLUSH) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Entered on an edge, so this check happens at least one cycle
            // later even when nothing was in flight.
            if (!in_flight) begin
               state_next   = ST_CLEAR;
               clr_next     = 1'b1;
               clr_cnt_next = '0;
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_reg   <= ST_INIT;
         clr_cnt_reg <= '0;
         clr_reg     <= 1'b1;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
         clr_reg     <= clr_next;
      end
   end

   // ------------------------------------------------------------------
   // Issue, tag pipe and result return
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         last_reg     <= 1'b1;
         a_reg        <= '0;
         b_reg        <= '0;
         s_reg        <= '0;
         iss_vld_reg  <= 1'b0;
         iss_id_reg   <= 1'b0;
         tag_vld_reg  <= '0;
         tag_id_reg   <= '0;
         rsp0_vld_reg <= 1'b0;
         rsp1_vld_reg <= 1'b0;
         rsp_y_reg    <= '0;
         rsp_c_reg    <= 1'b0;
         rsp_v_reg    <= 1'b0;
         rsp_z_reg    <= 1'b0;
      end else begin
         iss_vld_reg <= xfer;
         iss_id_reg  <= win_id;
         tag_vld_reg <= tag_vld_next;
         tag_id_reg  <= tag_id_next;

         if (xfer) begin
            last_reg <= win_id;
            a_reg    <= win_id ? req.REQ1_A : req.REQ0_A;
            b_reg    <= win_id ? req.REQ1_B : req.REQ0_B;
            s_reg    <= win_id ? req.REQ1_S : req.REQ0_S;
         end

         rsp0_vld_reg <= out_vld && !out_id;
         rsp1_vld_reg <= out_vld && out_id;
         if (out_vld) begin
            rsp_y_reg <= ALU_Y;
            rsp_c_reg <= ALU_C;
            rsp_v_reg <= ALU_V;
            rsp_z_reg <= ALU_Z;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign req.REQ0_READY = rdy0;
   assign req.REQ1_READY = rdy1;
   assign req.RSP0_VALID = rsp0_vld_reg;
   assign req.RSP1_VALID = rsp1_vld_reg;
   assign req.RSP_Y      = rsp_y_reg;
   assign req.RSP_C      = rsp_c_reg;
   assign req.RSP_V      = rsp_v_reg;
   assign req.RSP_Z      = rsp_z_reg;
   assign req.BUSY       = (state_reg != ST_RUN) || in_flight;

   assign ALU_A   = a_reg;
   assign ALU_B   = b_reg;
   assign ALU_S   = s_reg;
   assign ALU_CLR = clr_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Drives alu_arbiter through reset, a single operation, a table of
// back-to-back and contended cycles, a flush with operations in flight and a
// reset in the middle of an operation. A small behavioural ALU with a
// two-stage result pipeline stands in for the real datapath.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int DW = 8;
   localparam int OW = 4;

   // Opcode values used by the stand-in ALU only.
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_INCA = 4'h8;
   localparam logic [3:0] OP_DECA = 4'h9;

   logic          CLK;
   logic          CLR_N;
   logic [DW-1:0] ALU_A, ALU_B, ALU_Y;
   logic [OW-1:0] ALU_S;
   logic          ALU_CLR, ALU_C, ALU_V, ALU_Z;

   int n_checks = 0;
   int n_err    = 0;

   alu_arbiter_if #(.DWIDTH(DW), .OPWIDTH(OW)) bus ();

   alu_arbiter #(.DWIDTH(DW), .OPWIDTH(OW), .ALU_LAT(2), .CLR_CYC(2)) dut (
      .CLK     (CLK),
      .CLR_N   (CLR_N),
      .req     (bus),
      .ALU_A   (ALU_A),
      .ALU_B   (ALU_B),
      .ALU_S   (ALU_S),
      .ALU_CLR (ALU_CLR),
      .ALU_Y   (ALU_Y),
      .ALU_C   (ALU_C),
      .ALU_V   (ALU_V),
      .ALU_Z   (ALU_Z)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ---------------- stand-in ALU, latency 2 ----------------
   logic [10:0] st0, st1;   // {y, c, v, z}

   function automatic logic [10:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
      logic [8:0] r;
      logic       v;
      r = '0;
      v = 1'b0;
      case (s)
         OP_ADD:  begin r = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (r[7] != a[7]); end
         OP_XOR:  r = {1'b0, a ^ b};
         OP_INCA: begin r = {1'b0, a} + 9'd1; v = (a == 8'h7F); end
         OP_DECA: begin r = {1'b0, a} - 9'd1; v = (a == 8'h80); end
         default: r = '0;
      endcase
      return {r[7:0], r[8], v, (r[7:0] == 8'h00)};
   endfunction

   always @(posedge CLK) begin
      if (ALU_CLR) begin
         st0 <= '0;
         st1 <= '0;
      end else begin
         st0 <= alu_fn(ALU_A, ALU_B, ALU_S);
         st1 <= st0;
      end
   end
   assign {ALU_Y, ALU_C, ALU_V, ALU_Z} = st1;

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] s);
      bus.REQ0_VALID = v; bus.REQ0_A = a; bus.REQ0_B = b; bus.REQ0_S = s;
   endtask

   task automatic set_req1(input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] s);
      bus.REQ1_VALID = v; bus.REQ1_A = a; bus.REQ1_B = b; bus.REQ1_S = s;
   endtask

   // One record per cycle: inputs, expected grants in that cycle, expected
   // response strobes (and Y when a strobe is expected) seen in that cycle.
   typedef struct {
      logic       v0, v1;
      logic [7:0] a0, b0;
      logic [3:0] s0;
      logic [7:0] a1, b1;
      logic [3:0] s1;
      logic       r0, r1, p0, p1;
      logic [7:0] y;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   initial begin
      // ---- table: 8 xor ops from REQ1, then 6 contended cycles ----
      for (int t = 0; t < NV; t++) tbl[t] = '{default: '0};
      for (int i = 0; i < 8; i++) begin
         tbl[i].v1 = 1'b1; tbl[i].a1 = 8'(i); tbl[i].b1 = 8'hFF; tbl[i].s1 = OP_XOR;
         tbl[i].r1 = 1'b1;
         tbl[i+4].p1 = 1'b1; tbl[i+4].y = 8'hFF - 8'(i);
      end
      for (int j = 0; j < 6; j++) begin
         tbl[8+j].v0 = 1'b1; tbl[8+j].a0 = 8'h10; tbl[8+j].s0 = OP_INCA;
         tbl[8+j].v1 = 1'b1; tbl[8+j].a1 = 8'h10; tbl[8+j].s1 = OP_DECA;
         tbl[8+j].r0 = (j % 2 == 0);
         tbl[8+j].r1 = (j % 2 == 1);
         if (j % 2 == 0) begin tbl[12+j].p0 = 1'b1; tbl[12+j].y = 8'h11; end
         else            begin tbl[12+j].p1 = 1'b1; tbl[12+j].y = 8'h0F; end
      end

      // ---- reset ----
      CLR_N = 1'b0;
      bus.FLUSH = 1'b0;
      set_req0(1'b0, 8'h00, 8'h00, 4'h0);
      set_req1(1'b0, 8'h00, 8'h00, 4'h0);
      step(); step(); step();
      chk("rst_ready0", bus.REQ0_READY, 0);
      chk("rst_ready1", bus.REQ1_READY, 0);
      chk("rst_rspv",   {bus.RSP0_VALID, bus.RSP1_VALID}, 0);
      chk("rst_rsp",    {bus.RSP_Y, bus.RSP_C, bus.RSP_V, bus.RSP_Z}, 0);
      chk("rst_alu_ab", {ALU_A, ALU_B, ALU_S}, 0);
      chk("rst_clr",    ALU_CLR, 1);
      chk("rst_busy",   bus.BUSY, 1);

      // ---- release, INIT, then single add from REQ0 ----
      CLR_N = 1'b1;
      set_req0(1'b1, 8'h05, 8'h03, OP_ADD);
      #1;
      chk("init0_clr", ALU_CLR, 1);
      chk("init0_rdy", bus.REQ0_READY, 0);
      step();
      chk("init1_clr", ALU_CLR, 1);
      chk("init1_rdy", bus.REQ0_READY, 0);
      step();
      chk("run_clr",  ALU_CLR, 0);
      chk("run_rdy0", bus.REQ0_READY, 1);
      chk("run_busy", bus.BUSY, 0);
      step();
      set_req0(1'b0, 8'h00, 8'h00, 4'h0);
      chk("single_alu", {ALU_A, ALU_B, ALU_S}, {8'h05, 8'h03, OP_ADD});
      chk("single_busy", bus.BUSY, 1);
      step();
      chk("single_lat1", bus.RSP0_VALID, 0);
      step();
      chk("single_lat2", bus.RSP0_VALID, 0);
      step();
      chk("single_rspv", {bus.RSP0_VALID, bus.RSP1_VALID}, 2'b10);
      chk("single_y",    bus.RSP_Y, 8'h08);
      chk("single_cz",   {bus.RSP_C, bus.RSP_Z}, 2'b00);
      step();
      chk("single_pulse", bus.RSP0_VALID, 0);
      step();

      // ---- table-driven back-to-back and contention ----
      for (int t = 0; t < NV; t++) begin
         set_req0(tbl[t].v0, tbl[t].a0, tbl[t].b0, tbl[t].s0);
         set_req1(tbl[t].v1, tbl[t].a1, tbl[t].b1, tbl[t].s1);
         #1;
         chk($sformatf("tbl%0d_rdy0", t), bus.REQ0_READY, tbl[t].r0);
         chk($sformatf("tbl%0d_rdy1", t), bus.REQ1_READY, tbl[t].r1);
         chk($sformatf("tbl%0d_rsp0", t), bus.RSP0_VALID, tbl[t].p0);
         chk($sformatf("tbl%0d_rsp1", t), bus.RSP1_VALID, tbl[t].p1);
         if (tbl[t].p0 || tbl[t].p1)
            chk($sformatf("tbl%0d_y", t), bus.RSP_Y, tbl[t].y);
         $display("vec %0d: rdy=%b%b rsp=%b%b y=%02h", t, bus.REQ0_READY, bus.REQ1_READY,
                  bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP_Y);
         step();
      end
      set_req0(1'b0, 8'h00, 8'h00, 4'h0);
      set_req1(1'b0, 8'h00, 8'h00, 4'h0);

      // ---- flush with two ops in flight ----
      set_req0(1'b1, 8'h01, 8'h01, OP_ADD); #1;
      chk("fl_issue0", bus.REQ0_READY, 1);
      step();
      set_req0(1'b1, 8'h02, 8'h02, OP_ADD); #1;
      chk("fl_issue1", bus.REQ0_READY, 1);
      step();
      set_req0(1'b1, 8'h07, 8'h01, OP_ADD);
      bus.FLUSH = 1'b1; #1;
      chk("fl_suppress", {bus.REQ0_READY, bus.REQ1_READY}, 2'b00);
      step();
      bus.FLUSH = 1'b0; #1;
      chk("fl_drain_rdy", bus.REQ0_READY, 0);
      chk("fl_drain_busy", bus.BUSY, 1);
      chk("fl_drain_rsp", bus.RSP0_VALID, 0);
      step();
      chk("fl_rsp_a",   {bus.RSP0_VALID, bus.RSP_Y}, {1'b1, 8'h02});
      chk("fl_clr_a",   {ALU_CLR, bus.REQ0_READY}, 2'b00);
      step();
      chk("fl_rsp_b",   {bus.RSP0_VALID, bus.RSP_Y}, {1'b1, 8'h04});
      chk("fl_clr_b",   {ALU_CLR, bus.REQ0_READY}, 2'b00);
      step();
      chk("fl_clr_c",   {ALU_CLR, bus.REQ0_READY, bus.RSP0_VALID}, 3'b100);
      step();
      chk("fl_clr_d",   {ALU_CLR, bus.REQ0_READY}, 2'b10);
      step();
      chk("fl_resume",  {ALU_CLR, bus.REQ0_READY, bus.BUSY}, 3'b010);
      step();
      set_req0(1'b0, 8'h00, 8'h00, 4'h0);
      chk("fl_held_alu", {ALU_A, ALU_B}, {8'h07, 8'h01});
      step(); step(); step();
      chk("fl_held_rsp", {bus.RSP0_VALID, bus.RSP_Y}, {1'b1, 8'h08});
      step();

      // ---- reset in the middle of an operation ----
      set_req1(1'b1, 8'h20, 8'h01, OP_ADD); #1;
      chk("mr_issue", bus.REQ1_READY, 1);
      step();
      set_req1(1'b0, 8'h00, 8'h00, 4'h0);
      CLR_N = 1'b0; #1;
      chk("mr_async", {ALU_CLR, bus.BUSY, ALU_A}, {1'b1, 1'b1, 8'h00});
      step();
      CLR_N = 1'b1;
      set_req0(1'b1, 8'h30, 8'h0C, OP_ADD);
      set_req1(1'b1, 8'h40, 8'h01, OP_ADD); #1;
      chk("mr_init0", {ALU_CLR, bus.REQ0_READY, bus.REQ1_READY, bus.RSP1_VALID}, 4'b1000);
      step();
      chk("mr_init1", {ALU_CLR, bus.REQ0_READY, bus.REQ1_READY, bus.RSP1_VALID}, 4'b1000);
      step();
      chk("mr_run",   {ALU_CLR, bus.REQ0_READY, bus.REQ1_READY, bus.RSP1_VALID}, 4'b0100);
      step();
      set_req0(1'b0, 8'h00, 8'h00, 4'h0);
      set_req1(1'b0, 8'h00, 8'h00, 4'h0);
      chk("mr_alu", {ALU_A, ALU_B}, {8'h30, 8'h0C});
      chk("mr_norsp5", {bus.RSP0_VALID, bus.RSP1_VALID}, 0);
      step();
      chk("mr_norsp6", {bus.RSP0_VALID, bus.RSP1_VALID}, 0);
      step();
      chk("mr_norsp7", {bus.RSP0_VALID, bus.RSP1_VALID}, 0);
      step();
      chk("mr_rsp", {bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP_Y}, {2'b10, 8'h3C});
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
